// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared command and control-state encodings for the one-hot sequencer
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_INC   = 2'b01,
    MODE_DEC   = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int IN_W_MIN = 1;
  localparam int IN_W_MAX = 6;

endpackage

// File: rtl/decode_bin2onehot.sv
// rtl/decode_bin2onehot.sv - combinational binary index to one-hot decoder
module decode_bin2onehot #(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]      bin,
  output logic [2**IN_W-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[bin] = 1'b1;
  end

endmodule

// File: rtl/decoder_onehot_seq.sv
// rtl/decoder_onehot_seq.sv - registered one-hot select with load/inc/dec/clear commands and a one-deep output stage
module decoder_onehot_seq
  import decoder_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [IN_W-1:0]      In,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**IN_W-1:0]   Out,
  output logic [IN_W-1:0]      idx,
  output logic                 wrap
);

  localparam int OUT_W = 2**IN_W;

  mode_t             cmd;
  state_t            state;
  logic              accept;
  logic              out_zero;
  logic              nxt_zero;
  logic              nxt_wrap;
  logic [IN_W-1:0]   nxt_idx;
  logic [OUT_W-1:0]  nxt_onehot;
  logic [OUT_W-1:0]  nxt_out;

  assign cmd       = mode_t'(mode);
  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_zero  = (Out == '0);

  // Out/idx persist after consumption, so INC/DEC always step from the last result.
  always_comb begin
    nxt_idx  = idx;
    nxt_zero = 1'b0;
    nxt_wrap = 1'b0;
    case (cmd)
      MODE_LOAD: nxt_idx = In;
      MODE_INC: begin
        if (out_zero) begin
          nxt_idx = '0;
        end else begin
          nxt_idx  = idx + IN_W'(1);
          nxt_wrap = &idx;
        end
      end
      MODE_DEC: begin
        if (out_zero) begin
          nxt_idx = '0;
        end else begin
          nxt_idx  = idx - IN_W'(1);
          nxt_wrap = (idx == '0);
        end
      end
      MODE_CLEAR: begin
        nxt_idx  = '0;
        nxt_zero = 1'b1;
      end
      default: nxt_idx = idx;
    endcase
  end

  decode_bin2onehot #(.IN_W(IN_W)) u_dec (
    .bin    (nxt_idx),
    .onehot (nxt_onehot)
  );

  assign nxt_out = nxt_zero ? '0 : nxt_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      Out   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= accept && nxt_wrap;
      if (accept) begin
        Out <= nxt_out;
        idx <= nxt_idx;
      end
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (out_ready && !accept) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// tb/tb_decoder_onehot_seq.sv - scoreboard bench for decoder_onehot_seq at IN_W=2 and IN_W=3
module tb_decoder_onehot_seq;
  import decoder_pkg::*;

  typedef struct {
    logic [3:0] o;
    logic [1:0] i;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [1:0] In;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Out;
  logic [1:0] idx;
  logic       wrap;

  logic       rst3_n;
  logic       in_valid3;
  logic       in_ready3;
  logic [1:0] mode3;
  logic [2:0] in3;
  logic       out_valid3;
  logic       out_ready3;
  logic [7:0] out3;
  logic [2:0] idx3;
  logic       wrap3;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic mon_en = 1'b0;
  logic wrap_sched = 1'b0;
  logic acc_sched  = 1'b0;
  logic wrap_exp   = 1'b0;
  logic acc_exp    = 1'b0;

  decoder_onehot_seq #(.IN_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .In        (In),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .idx       (idx),
    .wrap      (wrap)
  );

  decoder_onehot_seq #(.IN_W(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst3_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (mode3),
    .In        (in3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .Out       (out3),
    .idx       (idx3),
    .wrap      (wrap3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one command; the expected result is queued the cycle it is seen to be accepted.
  task automatic send(input logic [1:0] m, input logic [1:0] v, input logic [3:0] eo,
                      input logic [1:0] ei, input logic ew, input logic rdy);
    bit done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      #1;
      in_valid  = 1'b1;
      mode      = m;
      In        = v;
      out_ready = rdy;
      #1;
      if (in_ready) begin
        exp_q.push_back('{o: eo, i: ei});
        wrap_sched = ew;
        acc_sched  = 1'b1;
        done       = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: got accepted=0 expected accepted=1 (mode %0d)", m);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = rdy;
    end
  endtask

  // Monitor: samples after the driver has settled inputs for the coming edge.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (mon_en) begin
      chk("wrap", 32'(wrap), 32'(wrap_exp));
      if (acc_exp) chk("latency_out_valid", 32'(out_valid), 32'd1);
      chk("onehot_invariant", 32'((Out == 4'b0) || (Out == (4'b0001 << idx))), 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got Out=%b idx=%0d expected no result", Out, idx);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (Out !== e.o || idx !== e.i) begin
            errors++;
            $display("FAIL result: got Out=%b idx=%0d expected Out=%b idx=%0d", Out, idx, e.o, e.i);
          end
        end
      end
      wrap_exp   = wrap_sched;
      acc_exp    = acc_sched;
      wrap_sched = 1'b0;
      acc_sched  = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = MODE_LOAD; In = 2'd0; out_ready = 1'b1;
    rst3_n = 1'b0; in_valid3 = 1'b0; mode3 = MODE_LOAD; in3 = 3'd0; out_ready3 = 1'b1;
    #2;
    chk("reset_Out", 32'(Out), 32'd0);
    chk("reset_idx", 32'(idx), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_no_accept", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    mon_en = 1'b1;

    send(MODE_LOAD, 2'd2, 4'b0100, 2'd2, 1'b0, 1'b1);
    idle(2, 1'b1);
    #1;
    chk("consumed_out_valid", 32'(out_valid), 32'd0);
    chk("consumed_Out_kept", 32'(Out), 32'b0100);

    send(MODE_LOAD, 2'd3, 4'b1000, 2'd3, 1'b0, 1'b1);
    send(MODE_INC,  2'd0, 4'b0001, 2'd0, 1'b1, 1'b1);
    send(MODE_DEC,  2'd0, 4'b1000, 2'd3, 1'b1, 1'b1);
    idle(2, 1'b1);

    send(MODE_LOAD, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      in_valid = 1'b1; mode = MODE_INC; In = 2'd0; out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_Out", 32'(Out), 32'b0010);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    send(MODE_INC, 2'd0, 4'b0100, 2'd2, 1'b0, 1'b1);
    idle(2, 1'b1);

    send(MODE_LOAD, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b1);
    send(MODE_INC,  2'd0, 4'b0010, 2'd1, 1'b0, 1'b1);
    send(MODE_INC,  2'd0, 4'b0100, 2'd2, 1'b0, 1'b1);
    send(MODE_INC,  2'd0, 4'b1000, 2'd3, 1'b0, 1'b1);
    send(MODE_INC,  2'd0, 4'b0001, 2'd0, 1'b1, 1'b1);

    send(MODE_CLEAR, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b1);
    send(MODE_INC,   2'd0, 4'b0001, 2'd0, 1'b0, 1'b1);
    send(MODE_CLEAR, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b1);
    send(MODE_DEC,   2'd0, 4'b0001, 2'd0, 1'b0, 1'b1);
    send(MODE_LOAD,  2'd2, 4'b0100, 2'd2, 1'b0, 1'b1);
    send(MODE_DEC,   2'd0, 4'b0010, 2'd1, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // IN_W=3 instance: asynchronous reset while holding a result.
    @(negedge clk);
    #1;
    in_valid3 = 1'b1; mode3 = MODE_LOAD; in3 = 3'd7; out_ready3 = 1'b0;
    #1;
    chk("w3_in_ready", 32'(in_ready3), 32'd1);
    @(negedge clk);
    #1;
    in_valid3 = 1'b0;
    chk("w3_Out_full", 32'(out3), 32'h80);
    chk("w3_out_valid_full", 32'(out_valid3), 32'd1);
    #1;
    rst3_n = 1'b0;
    #1;
    chk("w3_async_Out", 32'(out3), 32'd0);
    chk("w3_async_idx", 32'(idx3), 32'd0);
    chk("w3_async_out_valid", 32'(out_valid3), 32'd0);
    chk("w3_async_in_ready", 32'(in_ready3), 32'd1);
    in_valid3 = 1'b1; mode3 = MODE_LOAD; in3 = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("w3_reset_no_accept", 32'(out3), 32'd0);
    @(negedge clk);
    in_valid3 = 1'b0;
    rst3_n = 1'b1;
    @(negedge clk);
    #1;
    in_valid3 = 1'b1; mode3 = MODE_INC; out_ready3 = 1'b1;
    @(negedge clk);
    #1;
    in_valid3 = 1'b0;
    chk("w3_first_inc_Out", 32'(out3), 32'h01);
    chk("w3_first_inc_idx", 32'(idx3), 32'd0);
    chk("w3_first_inc_wrap", 32'(wrap3), 32'd0);
    chk("w3_first_inc_valid", 32'(out_valid3), 32'd1);

    idle(2, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
